// File: rtl/usb_audio_pkg.sv
// Shared types and constants for the USB audio OUT-endpoint sink.
// USB_AUDIO_UNSIGNED_OUT_EN selects offset-binary (MSB-inverted) output samples.
package usb_audio_pkg;

  typedef enum logic [0:0] {
    PREFILL = 1'b0,
    PLAY    = 1'b1
  } usb_audio_state_t;

  localparam int USB_AUDIO_CLK_HZ = 60_000_000;

`ifdef USB_AUDIO_UNSIGNED_OUT_EN
  localparam bit USB_AUDIO_UNSIGNED_OUT = 1'b1;
`else
  localparam bit USB_AUDIO_UNSIGNED_OUT = 1'b0;
`endif

  // Per-channel silence word; only the low sw bits are meaningful.
  function automatic logic [31:0] usb_audio_silence(input int sw);
    return USB_AUDIO_UNSIGNED_OUT ? (32'h1 << (sw - 1)) : 32'h0;
  endfunction

endpackage

// File: rtl/usb_audio_frame_fifo.sv
// Synchronous frame FIFO with registered-read RAM and wrap-bit pointers.
// Writes when full and reads when empty are ignored.
module usb_audio_frame_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 128
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_en,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_ok;
  logic         rd_ok;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LW'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // RAM kept reset-free so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    if (rd_ok) rd_data <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/usb_audio_stream_sink.sv
// USB audio OUT sink: assembles little-endian bytes into CH x SW frames, buffers
// them and plays one frame per CLK_DIV cycles. USB_AUDIO_UNSIGNED_OUT_EN -> offset binary.
module usb_audio_stream_sink
  import usb_audio_pkg::*;
#(
  parameter int CH          = 2,
  parameter int SW          = 16,
  parameter int DEPTH       = 128,
  parameter int CLK_DIV     = 1250,
  parameter int START_LEVEL = DEPTH / 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         pkt_start,
  output logic [CH*SW-1:0]             pcm_data,
  output logic                         pcm_strobe,
  output logic                         playing,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [15:0]                  overrun_cnt,
  output logic [15:0]                  underrun_cnt
);

  localparam int FW = CH * SW;
  localparam int NB = SW / 8;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [31:0]   SIL_WORD  = usb_audio_silence(SW);
  // Silence frame doubles as the MSB-inversion mask in offset-binary builds.
  localparam logic [FW-1:0] SIL_FRAME = {CH{SIL_WORD[SW-1:0]}};
  localparam logic [1:0]    BYTE_LAST = 2'(NB - 1);
  localparam logic [2:0]    CH_LAST   = 3'(CH - 1);
  localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);

  logic [1:0]       byte_cnt, byte_idx;
  logic [2:0]       ch_cnt, ch_idx;
  logic [FW-1:0]    frame_q, frame_d;
  logic             commit;
  logic [DW-1:0]    div_q;
  logic             tick;
  logic             pop, underrun;
  logic             pop_q, underrun_q;
  logic             fifo_full, fifo_empty;
  logic [FW-1:0]    rd_data;
  usb_audio_state_t state_q, state_d;

  // pkt_start realigns so a coincident byte lands in byte 0 of channel 0.
  always_comb begin
    byte_idx = pkt_start ? 2'd0 : byte_cnt;
    ch_idx   = pkt_start ? 3'd0 : ch_cnt;
    frame_d  = frame_q;
    for (int i = 0; i < CH * NB; i++) begin
      if (in_valid && (int'(ch_idx) * NB + int'(byte_idx) == i)) frame_d[i*8 +: 8] = in_data;
    end
    commit = in_valid && (byte_idx == BYTE_LAST) && (ch_idx == CH_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt <= '0;
      ch_cnt   <= '0;
      frame_q  <= '0;
    end else if (in_valid) begin
      frame_q <= frame_d;
      if (byte_idx == BYTE_LAST) begin
        byte_cnt <= '0;
        ch_cnt   <= (ch_idx == CH_LAST) ? 3'd0 : ch_idx + 3'd1;
      end else begin
        byte_cnt <= byte_idx + 2'd1;
        ch_cnt   <= ch_idx;
      end
    end else if (pkt_start) begin
      byte_cnt <= '0;
      ch_cnt   <= '0;
    end
  end

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div_q <= '0;
    else       div_q <= tick ? '0 : div_q + DW'(1);
  end

  usb_audio_frame_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (commit),
    .wr_data (frame_d),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= PREFILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    underrun = 1'b0;
    case (state_q)
      PREFILL: if (fill_level >= START_LVL) state_d = PLAY;
      PLAY: begin
        if (tick) begin
          if (fifo_empty) begin
            underrun = 1'b1;
            state_d  = PREFILL;
          end else begin
            pop = 1'b1;
          end
        end
      end
      default: state_d = PREFILL;
    endcase
  end

  assign playing = (state_q == PLAY);

  // One stage for the RAM read, one for the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pop_q      <= 1'b0;
      underrun_q <= 1'b0;
      pcm_strobe <= 1'b0;
      pcm_data   <= SIL_FRAME;
    end else begin
      pop_q      <= pop;
      underrun_q <= underrun;
      pcm_strobe <= pop_q | underrun_q;
      if (pop_q)           pcm_data <= rd_data ^ SIL_FRAME;
      else if (underrun_q) pcm_data <= SIL_FRAME;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_cnt  <= '0;
      underrun_cnt <= '0;
    end else begin
      if (commit && fifo_full && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
      if (underrun && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_usb_audio_stream_sink.sv
// Self-checking bench for usb_audio_stream_sink: three parameterisations share one
// input stream; instance A is tracked cycle by cycle by a queue-based reference model.
module tb_usb_audio_stream_sink;

  localparam int A_CH = 2, A_SW = 16, A_DEPTH = 8, A_DIV = 10, A_START = 4;

`ifdef USB_AUDIO_UNSIGNED_OUT_EN
  localparam logic [31:0] A_SIL = 32'h8000_8000;
  localparam logic [71:0] B_SIL = 72'h800000_800000_800000;
`else
  localparam logic [31:0] A_SIL = 32'h0;
  localparam logic [71:0] B_SIL = 72'h0;
`endif

  logic       clk;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       pkt_start;

  logic [31:0] pcm_data_a;
  logic        pcm_strobe_a, playing_a;
  logic [3:0]  fill_level_a;
  logic [15:0] overrun_cnt_a, underrun_cnt_a;

  logic [71:0] pcm_data_b;
  logic        pcm_strobe_b, playing_b;
  logic [2:0]  fill_level_b;
  logic [15:0] overrun_cnt_b, underrun_cnt_b;

  logic [31:0] pcm_data_c;
  logic        pcm_strobe_c, playing_c;
  logic [3:0]  fill_level_c;
  logic [15:0] overrun_cnt_c, underrun_cnt_c;

  int checks;
  int errors;

  usb_audio_stream_sink #(.CH(A_CH), .SW(A_SW), .DEPTH(A_DEPTH), .CLK_DIV(A_DIV), .START_LEVEL(A_START)) u_dut_a (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .pkt_start(pkt_start),
    .pcm_data(pcm_data_a), .pcm_strobe(pcm_strobe_a), .playing(playing_a), .fill_level(fill_level_a),
    .overrun_cnt(overrun_cnt_a), .underrun_cnt(underrun_cnt_a));

  usb_audio_stream_sink #(.CH(3), .SW(24), .DEPTH(4), .CLK_DIV(10), .START_LEVEL(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .pkt_start(pkt_start),
    .pcm_data(pcm_data_b), .pcm_strobe(pcm_strobe_b), .playing(playing_b), .fill_level(fill_level_b),
    .overrun_cnt(overrun_cnt_b), .underrun_cnt(underrun_cnt_b));

  usb_audio_stream_sink #(.CH(2), .SW(16), .DEPTH(8), .CLK_DIV(200), .START_LEVEL(8)) u_dut_c (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .pkt_start(pkt_start),
    .pcm_data(pcm_data_c), .pcm_strobe(pcm_strobe_c), .playing(playing_c), .fill_level(fill_level_c),
    .overrun_cnt(overrun_cnt_c), .underrun_cnt(underrun_cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for instance A: a frame queue, a byte list for the frame being
  // built, and a list of outputs due at a given clock edge.
  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } pend_t;

  logic [31:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  pend_t       m_pend[$];
  int          m_div;
  int unsigned m_cyc;
  int          m_fill_before;
  bit          m_tick;
  logic [31:0] m_frame;
  logic [31:0] m_pcm;
  logic        m_strobe;
  logic        m_playing;
  logic [15:0] m_ovr, m_und;

  initial m_cyc = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_fifo.delete();
      m_bytes.delete();
      m_pend.delete();
      m_div     = 0;
      m_playing = 1'b0;
      m_ovr     = 16'h0;
      m_und     = 16'h0;
      m_pcm     = A_SIL;
      m_strobe  = 1'b0;
    end else begin
      m_cyc++;
      m_strobe = 1'b0;
      if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
        m_pcm    = m_pend[0].val;
        m_strobe = 1'b1;
        void'(m_pend.pop_front());
      end
      m_fill_before = m_fifo.size();
      m_tick = (m_div == A_DIV - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      if (m_playing) begin
        if (m_tick) begin
          if (m_fill_before == 0) begin
            if (m_und != 16'hFFFF) m_und++;
            m_playing = 1'b0;
            m_pend.push_back('{due: m_cyc + 1, val: A_SIL});
          end else begin
            m_pend.push_back('{due: m_cyc + 1, val: m_fifo.pop_front() ^ A_SIL});
          end
        end
      end else if (m_fill_before >= A_START) begin
        m_playing = 1'b1;
      end
      if (pkt_start) m_bytes.delete();
      if (in_valid) begin
        m_bytes.push_back(in_data);
        if (m_bytes.size() == A_CH * A_SW / 8) begin
          m_frame = 32'h0;
          for (int i = 0; i < m_bytes.size(); i++) m_frame = m_frame | (32'(m_bytes[i]) << (8 * i));
          if (m_fill_before >= A_DEPTH) begin
            if (m_ovr != 16'hFFFF) m_ovr++;
          end else begin
            m_fifo.push_back(m_frame);
          end
          m_bytes.delete();
        end
      end
    end
  end

  task automatic next_cycle(input logic [7:0] d, input logic v, input logic s);
    @(negedge clk);
    in_data   = d;
    in_valid  = v;
    pkt_start = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    in_valid  = 1'b0;
    pkt_start = 1'b0;
    in_data   = 8'h00;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pcm_data_a !== A_SIL) begin errors++; $display("[TB] FAIL reset_pcm_a got %h want %h", pcm_data_a, A_SIL); end
    checks++; if (pcm_strobe_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe_a got %b want 0", pcm_strobe_a); end
    checks++; if (playing_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_playing_a got %b want 0", playing_a); end
    checks++; if (fill_level_a !== 4'd0) begin errors++; $display("[TB] FAIL reset_fill_a got %0d want 0", fill_level_a); end
    checks++; if (overrun_cnt_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_ovr_a got %0d want 0", overrun_cnt_a); end
    checks++; if (underrun_cnt_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_und_a got %0d want 0", underrun_cnt_a); end
    checks++; if (pcm_data_b !== B_SIL) begin errors++; $display("[TB] FAIL reset_pcm_b got %h want %h", pcm_data_b, B_SIL); end
    checks++; if (fill_level_c !== 4'd0) begin errors++; $display("[TB] FAIL reset_fill_c got %0d want 0", fill_level_c); end
  endtask

  task automatic test_playback();
    int strobes, good, seen_play, last_c;
    strobes = 0; good = 0; seen_play = 0; last_c = -1;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      next_cycle(8'h01, 1'b1, f == 0);
      next_cycle(8'h00, 1'b1, 1'b0);
      next_cycle(8'h02, 1'b1, 1'b0);
      next_cycle(8'h00, 1'b1, 1'b0);
    end
    next_cycle(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 90; c++) begin
      checks++; if (pcm_strobe_a !== m_strobe) begin errors++; $display("[TB] FAIL play_strobe got %b want %b", pcm_strobe_a, m_strobe); end
      checks++; if (pcm_data_a !== m_pcm) begin errors++; $display("[TB] FAIL play_pcm got %h want %h", pcm_data_a, m_pcm); end
      if (playing_a === 1'b1) seen_play = 1;
      if (pcm_strobe_a === 1'b1) begin
        if (strobes < 4 && pcm_data_a === (32'h0002_0001 ^ A_SIL)) good++;
        if (last_c >= 0) begin
          checks++; if (c - last_c != A_DIV) begin errors++; $display("[TB] FAIL play_strobe_gap got %0d want %0d", c - last_c, A_DIV); end
        end
        last_c = c;
        strobes++;
      end
      next_cycle(8'h00, 1'b0, 1'b0);
    end
    checks++; if (seen_play != 1) begin errors++; $display("[TB] FAIL play_seen_playing got %0d want 1", seen_play); end
    checks++; if (good != 4) begin errors++; $display("[TB] FAIL play_frames got %0d want 4", good); end
    checks++; if (strobes != 5) begin errors++; $display("[TB] FAIL play_strobe_count got %0d want 5", strobes); end
    checks++; if (underrun_cnt_a !== 16'd1) begin errors++; $display("[TB] FAIL underrun_cnt got %0d want 1", underrun_cnt_a); end
    checks++; if (playing_a !== 1'b0) begin errors++; $display("[TB] FAIL underrun_playing got %b want 0", playing_a); end
    checks++; if (pcm_data_a !== A_SIL) begin errors++; $display("[TB] FAIL underrun_pcm got %h want %h", pcm_data_a, A_SIL); end
  endtask

  task automatic test_pkt_start();
    logic [31:0] first_v, second_v;
    int n;
    first_v = 32'h0; second_v = 32'h0; n = 0;
    do_reset();
    next_cycle(8'h01, 1'b1, 1'b1);
    next_cycle(8'h02, 1'b1, 1'b0);
    next_cycle(8'h03, 1'b1, 1'b0);
    next_cycle(8'h00, 1'b0, 1'b1);
    next_cycle(8'hAA, 1'b1, 1'b0);
    next_cycle(8'hBB, 1'b1, 1'b0);
    next_cycle(8'hCC, 1'b1, 1'b0);
    next_cycle(8'hDD, 1'b1, 1'b0);
    next_cycle(8'h55, 1'b1, 1'b0);
    next_cycle(8'h10, 1'b1, 1'b1);
    next_cycle(8'h20, 1'b1, 1'b0);
    next_cycle(8'h30, 1'b1, 1'b0);
    next_cycle(8'h40, 1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      next_cycle(8'h01, 1'b1, 1'b0);
      next_cycle(8'h00, 1'b1, 1'b0);
      next_cycle(8'h02, 1'b1, 1'b0);
      next_cycle(8'h00, 1'b1, 1'b0);
    end
    next_cycle(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 60; c++) begin
      checks++; if (pcm_data_a !== m_pcm) begin errors++; $display("[TB] FAIL pkt_pcm got %h want %h", pcm_data_a, m_pcm); end
      if (pcm_strobe_a === 1'b1) begin
        if (n == 0) first_v = pcm_data_a;
        if (n == 1) second_v = pcm_data_a;
        n++;
      end
      next_cycle(8'h00, 1'b0, 1'b0);
    end
    checks++; if (first_v !== (32'hDDCC_BBAA ^ A_SIL)) begin errors++; $display("[TB] FAIL pkt_realign got %h want %h", first_v, 32'hDDCC_BBAA ^ A_SIL); end
    checks++; if (second_v !== (32'h4030_2010 ^ A_SIL)) begin errors++; $display("[TB] FAIL pkt_same_cycle got %h want %h", second_v, 32'h4030_2010 ^ A_SIL); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    next_cycle(8'hAA, 1'b1, 1'b0);
    next_cycle(8'hBB, 1'b1, 1'b0);
    do_reset();
    next_cycle(8'h11, 1'b1, 1'b0);
    next_cycle(8'h22, 1'b1, 1'b0);
    next_cycle(8'h00, 1'b0, 1'b0);
    checks++; if (fill_level_a !== 4'd0) begin errors++; $display("[TB] FAIL midreset_partial got %0d want 0", fill_level_a); end
    next_cycle(8'h33, 1'b1, 1'b0);
    next_cycle(8'h44, 1'b1, 1'b0);
    next_cycle(8'h00, 1'b0, 1'b0);
    checks++; if (fill_level_a !== 4'd1) begin errors++; $display("[TB] FAIL midreset_commit got %0d want 1", fill_level_a); end
  endtask

  task automatic test_three_channel();
    logic [7:0] b3 [9];
    logic       found;
    logic [71:0] want;
    b3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    want = 72'h998877_665544_332211 ^ B_SIL;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) next_cycle(b3[i], 1'b1, i == 0);
    next_cycle(8'h00, 1'b0, 1'b0);
    for (int c = 0; c < 40 && !found; c++) begin
      if (pcm_strobe_b === 1'b1) found = 1'b1;
      else next_cycle(8'h00, 1'b0, 1'b0);
    end
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL ch3_strobe_timeout got %b want 1", found); end
    if (found) begin
      checks++; if (pcm_data_b !== want) begin errors++; $display("[TB] FAIL ch3_pcm got %h want %h", pcm_data_b, want); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int f = 0; f < 10; f++) begin
      next_cycle(8'(f), 1'b1, f == 0);
      next_cycle(8'h00, 1'b1, 1'b0);
      next_cycle(8'(f + 1), 1'b1, 1'b0);
      next_cycle(8'h00, 1'b1, 1'b0);
    end
    next_cycle(8'h00, 1'b0, 1'b0);
    checks++; if (fill_level_c !== 4'd8) begin errors++; $display("[TB] FAIL ovr_fill got %0d want 8", fill_level_c); end
    checks++; if (overrun_cnt_c !== 16'd2) begin errors++; $display("[TB] FAIL ovr_count got %0d want 2", overrun_cnt_c); end
    checks++; if (playing_c !== 1'b1) begin errors++; $display("[TB] FAIL ovr_playing got %b want 1", playing_c); end
  endtask

  task automatic test_random();
    int rate;
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph % 2 == 0) ? 85 : 12;
      for (int c = 0; c < 400; c++) begin
        next_cycle(8'($urandom), ($urandom_range(99) < rate), ($urandom_range(49) == 0));
        checks++; if (pcm_data_a !== m_pcm) begin errors++; $display("[TB] FAIL rnd_pcm got %h want %h", pcm_data_a, m_pcm); end
        checks++; if (pcm_strobe_a !== m_strobe) begin errors++; $display("[TB] FAIL rnd_strobe got %b want %b", pcm_strobe_a, m_strobe); end
        checks++; if (playing_a !== m_playing) begin errors++; $display("[TB] FAIL rnd_playing got %b want %b", playing_a, m_playing); end
        checks++; if (fill_level_a !== 4'(m_fifo.size())) begin errors++; $display("[TB] FAIL rnd_fill got %0d want %0d", fill_level_a, m_fifo.size()); end
        checks++; if (overrun_cnt_a !== m_ovr) begin errors++; $display("[TB] FAIL rnd_ovr got %0d want %0d", overrun_cnt_a, m_ovr); end
        checks++; if (underrun_cnt_a !== m_und) begin errors++; $display("[TB] FAIL rnd_und got %0d want %0d", underrun_cnt_a, m_und); end
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    pkt_start = 1'b0;
    test_reset();
    test_playback();
    test_pkt_start();
    test_reset_mid_packet();
    test_three_channel();
    test_overrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog_timeout reached without finishing");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/usb_audio_stream_sink.md
# usb_audio_stream_sink

Parametrised USB Audio OUT-endpoint sink. It assembles the little-endian byte stream from the USB full-speed core's OUT data port into multi-channel PCM frames and buffers them in a frame FIFO. Frames are played out at a fixed sample rate derived from the 60 MHz system clock, with prefill, underrun recovery and overrun dropping. It sits between `usbfs_core_top` (`out_data`/`out_valid`) and the audio DAC interface, and replaces fixed 2-channel/16-bit ping-pong buffering.

## Interface
Parameters:
- `CH`, 2: channels per frame, 1..8.
- `SW`, 16: sample width in bits; must be one of 8, 16, 24, 32.
- `DEPTH`, 128: FIFO depth in frames; power of 2, 4..1024.
- `CLK_DIV`, 1250: `clk` cycles per sample period (60 MHz / 48 kHz).
- `START_LEVEL`, `DEPTH/2`: FIFO fill in frames required to begin or resume playback; 1..`DEPTH`.

Ports:
- `clk`  in  1  system clock, 60 MHz.
- `rstn`  in  1  reset, asynchronous, active-low.
- `in_data`  in  8  OUT-endpoint payload byte.
- `in_valid`  in  1  `in_data` valid for this cycle; no backpressure.
- `pkt_start`  in  1  one-cycle pulse at the start of each OUT data packet; realigns frame assembly.
- `pcm_data`  out  `CH*SW`  current frame; channel 0 in the LSBs.
- `pcm_strobe`  out  1  one-cycle pulse when `pcm_data` is updated.
- `playing`  out  1  1 while in state PLAY.
- `fill_level`  out  `$clog2(DEPTH+1)`  frames currently held in the FIFO.
- `overrun_cnt`  out  16  count of dropped frames; saturates at 0xFFFF.
- `underrun_cnt`  out  16  count of underrun events; saturates at 0xFFFF.

## Operation
- Assembler: a byte counter runs 0..`SW/8-1` and a channel counter runs 0..`CH-1`. Bytes are little-endian; channel order follows the stream.
- The last byte of the last channel commits the full frame to the FIFO.
- `pkt_start` clears both counters and discards any partial frame. When `pkt_start` and `in_valid` occur in the same cycle, the byte is taken as byte 0 of channel 0.
- Commit when the FIFO is full: the frame is dropped, `overrun_cnt` increments, and FIFO contents are unchanged.
- Sample tick: a divider counts 0..`CLK_DIV-1` and wraps. The tick asserts when the count equals `CLK_DIV-1`. The divider free-runs in all states.
- States:
  - PREFILL (reset state): no pops; `pcm_data` holds silence. Move to PLAY when `fill_level >= START_LEVEL`.
  - PLAY: each tick pops one frame. A tick with `fill_level == 0` is an underrun: `underrun_cnt` increments, `pcm_data` is set to silence, `pcm_strobe` pulses, and the state moves to PREFILL.
- Silence is all-zero per channel (two's complement). See Configuration for the offset-binary case.
- A commit and a pop in the same cycle both take effect; `fill_level` is unchanged.
- Reset mid-packet clears the assembler, FIFO, counters and state. The partial frame is lost.

## Timing
- Reset values: `pcm_data` = silence; `pcm_strobe` = 0; `playing` = 0; `fill_level` = 0; `overrun_cnt` = 0; `underrun_cnt` = 0.
- Commit on cycle N (last byte accepted): `fill_level` reflects the frame at the N+1 register output.
- Tick on cycle T in PLAY: the FIFO read is issued at T. `pcm_data` and `pcm_strobe` update at T+2 (registered RAM read plus output register). `pcm_strobe` is high for exactly one cycle.
- PREFILL→PLAY: `playing` rises the cycle after the fill condition is met. The first pop occurs on the next tick.
- Underrun at tick T: silence and `pcm_strobe` at T+2. `playing` falls at T+1.
- The FIFO is full at `fill_level == DEPTH` and empty at 0. Pointers are `$clog2(DEPTH)` bits wide plus a wrap bit.

## Configuration
- `USB_AUDIO_UNSIGNED_OUT_EN` defined: each output channel's MSB is inverted (offset binary for unsigned DACs). Silence and the reset value become `1<<(SW-1)` per channel.
- Not defined: samples pass through as two's complement. Silence and the reset value are 0.

## Structure
- Shared package `usb_audio_pkg`:
  - state enum `usb_audio_state_t` (PREFILL, PLAY);
  - constant `USB_AUDIO_CLK_HZ` = 60_000_000;
  - function `usb_audio_silence(SW)` returning the per-channel silence word.
- One sub-module `usb_audio_frame_fifo`: synchronous FIFO, width `CH*SW`, depth `DEPTH`. It holds an inferred registered-read RAM and provides full/empty/level outputs.

## Test plan
- CH=2, SW=16, DEPTH=8, START_LEVEL=4, CLK_DIV=10:
  - stream bytes 01 00 02 00 repeated 4 frames → `playing`=1; `pcm_data`=0x0002_0001 with strobes every 10 cycles.
  - after 4 frames with no new data, next tick → `underrun_cnt`=1, `pcm_data`=0, `playing`=0.
  - push 10 frames without ticks reaching PLAY pops (hold in PREFILL) → `fill_level`=8, `overrun_cnt`=2.
  - send 3 bytes, pulse `pkt_start`, then AA BB CC DD → committed frame is 0xDDCC_BBAA.
- CH=3, SW=24: bytes 11 22 33 44 55 66 77 88 99 → after playback, `pcm_data` = {0x998877, 0x665544, 0x332211}.
- With `USB_AUDIO_UNSIGNED_OUT_EN`, SW=16: after reset `pcm_data`=0x8000_8000; input sample 0x0001 → output 0x8001.
